// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: ping-pong frame buffer between camera writer and display reader.
// Latency: read data registered, 1 cycle after regread; bank swap takes effect next cycle.
// Backpressure: none; writes are silently dropped while a finished frame awaits the reader.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   addr_in/data_in/regwrite/frame_done  - writer side (write bank = bank_wr)
//   addr_out/regread/rd_vsync            - reader side (read bank = ~bank_wr)
//   data_out/data_valid   - registered read data and its one-cycle valid
//   bank_wr/swap_pending  - current write bank, frame-waiting-for-swap flag
//   drop_cnt              - saturating dropped-frame count when FB_DROPCNT_EN is
//                           defined, otherwise tied to 0
module frame_buffer_pp #(
  parameter int DW    = 16,
  parameter int AW    = 17,
  parameter int DEPTH = 76800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic          regwrite,
  input  logic          frame_done,
  input  logic [AW-1:0] addr_out,
  input  logic          regread,
  input  logic          rd_vsync,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          bank_wr,
  output logic          swap_pending,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e        state_q;
  logic          bank_q;
  logic [DW-1:0] data_out_q;
  logic          data_valid_q;

  // Not reset: frame contents survive rst.
  logic [DW-1:0] mem [0:1][0:DEPTH-1];

  logic wr_en;
  logic rd_in_range;

  // The write bank freezes once a frame is complete, so a late writer can
  // never corrupt the frame the reader is about to pick up.
  assign wr_en       = !rst && regwrite && (addr_in <= LAST_ADDR) && (state_q == IDLE);
  assign rd_in_range = (addr_out <= LAST_ADDR);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bank_q][addr_in] <= data_in;
    end
  end

  // Reads always target the opposite bank, so they can never collide with writes.
  // In the swap cycle bank_q still holds the old value, so that read sees the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= regread;
      if (regread) begin
        data_out_q <= rd_in_range ? mem[~bank_q][addr_out] : '0;
      end
    end
  end

  // Swap decision looks only at the registered state, so frame_done and
  // rd_vsync arriving together in IDLE arm the swap but do not perform it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_done) begin
            state_q <= PENDING;
          end
        end
        PENDING: begin
          if (rd_vsync) begin
            bank_q  <= ~bank_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FB_DROPCNT_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;
  logic       drop_evt;

  // A frame finishing while the previous one is still waiting was written
  // into a frozen bank, i.e. it is lost.
  assign drop_evt = (state_q == PENDING) && frame_done;
  assign drop_d   = (drop_evt && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign bank_wr      = bank_q;
  assign swap_pending = (state_q == PENDING);

endmodule
